// File: rtl/neuron_pkg.sv
// Shared types and constants for the accumulate-and-fire neuron stage.
// Holds the data width, the saturation ceiling, the FSM state type and the capture rule.
package neuron_pkg;

  localparam int NW = 10;
  localparam logic [NW-1:0] VMAX = 10'h3FF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    REFRAC = 2'd2
  } nf_state_t;

  // A carry out of the adder means the true sum exceeded VMAX.
  function automatic logic [NW-1:0] capture_value(input logic sat,
                                                  input logic cout,
                                                  input logic [NW-1:0] sum);
    logic [NW-1:0] v;
    if (sat && cout) begin
      v = VMAX;
    end else begin
      v = sum;
    end
    return v;
  endfunction

endpackage

// File: rtl/neuron_accum_fire_if.sv
// Weight handshake plus the operand/result wiring to the external adder.
// The neuron block is the slave; the weight source and adder form the master side.
interface neuron_accum_fire_if;
  import neuron_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [NW-1:0] in_weight;
  logic [NW-1:0] add_a;
  logic [NW-1:0] add_b;
  logic [NW-1:0] add_sum;
  logic          add_cout;

  modport master (
    output in_valid, in_weight, add_sum, add_cout,
    input  in_ready, add_a, add_b
  );

  modport slave (
    input  in_valid, in_weight, add_sum, add_cout,
    output in_ready, add_a, add_b
  );

endinterface

// File: rtl/cyc_timer.sv
// 4-bit loadable down-counter shared by the settle and refractory phases.
// Counts down to zero and parks there; zero flags the last cycle of a phase.
module cyc_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] cnt_r;

  // Load wins over the decrement; clear wins over both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 4'd0;
    end else if (clear) begin
      cnt_r <= 4'd0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != 4'd0) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == 4'd0);

endmodule

// File: rtl/neuron_accum_fire.sv
// Membrane-potential accumulator: feeds vmem and a latched weight to an external adder,
// captures the settled sum, and fires a one-cycle spike with a refractory hold-off.
module neuron_accum_fire
  import neuron_pkg::*;
#(
  parameter int            SETTLE_CYC = 4,
  parameter int            REFRAC_CYC = 3,
  parameter logic [NW-1:0] VRESET     = 10'd0,
  parameter bit            SAT        = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  neuron_accum_fire_if.slave   nf,
  input  logic [NW-1:0]        thresh,
  output logic                 spike,
  output logic [NW-1:0]        vmem
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);
  localparam logic [3:0] REFRAC_LOAD = (REFRAC_CYC > 0) ? 4'(REFRAC_CYC - 1) : 4'd0;

  nf_state_t     state_r, state_n_s;
  logic [NW-1:0] vmem_r, vmem_n_s;
  logic [NW-1:0] add_b_r, add_b_n_s;
  logic          spike_r, spike_n_s;
  logic          in_ready_r, in_ready_n_s;
  logic          tmr_load_s;
  logic [3:0]    tmr_val_s;
  logic          tmr_zero_s;
  logic          accept_s;
  logic [NW-1:0] newv_s;
  logic          fire_s;

  cyc_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .zero     (tmr_zero_s)
  );

  // Next-state and next-output logic; in_ready trails the return to IDLE by one cycle.
  always_comb begin
    state_n_s  = state_r;
    vmem_n_s   = vmem_r;
    add_b_n_s  = add_b_r;
    spike_n_s  = 1'b0;
    tmr_load_s = 1'b0;
    tmr_val_s  = 4'd0;
    accept_s   = nf.in_valid && in_ready_r && (state_r == IDLE);
    newv_s     = capture_value(SAT, nf.add_cout, nf.add_sum);
    fire_s     = (newv_s >= thresh);

    case (state_r)
      IDLE: begin
        if (accept_s) begin
          add_b_n_s  = nf.in_weight;
          tmr_load_s = 1'b1;
          tmr_val_s  = SETTLE_LOAD;
          state_n_s  = SETTLE;
        end else begin
          state_n_s  = IDLE;
        end
      end
      SETTLE: begin
        if (tmr_zero_s) begin
          add_b_n_s = {NW{1'b0}};
          if (fire_s) begin
            spike_n_s = 1'b1;
            vmem_n_s  = VRESET;
            if (REFRAC_CYC > 0) begin
              tmr_load_s = 1'b1;
              tmr_val_s  = REFRAC_LOAD;
              state_n_s  = REFRAC;
            end else begin
              state_n_s  = IDLE;
            end
          end else begin
            vmem_n_s  = newv_s;
            state_n_s = IDLE;
          end
        end else begin
          state_n_s = SETTLE;
        end
      end
      REFRAC: begin
        if (tmr_zero_s) begin
          state_n_s = IDLE;
        end else begin
          state_n_s = REFRAC;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase

    in_ready_n_s = (state_r == IDLE) && !accept_s;
  end

  // State and output registers; clear discards any capture in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      vmem_r     <= {NW{1'b0}};
      add_b_r    <= {NW{1'b0}};
      spike_r    <= 1'b0;
      in_ready_r <= 1'b1;
    end else if (clear) begin
      state_r    <= IDLE;
      vmem_r     <= {NW{1'b0}};
      add_b_r    <= {NW{1'b0}};
      spike_r    <= 1'b0;
      in_ready_r <= 1'b1;
    end else begin
      state_r    <= state_n_s;
      vmem_r     <= vmem_n_s;
      add_b_r    <= add_b_n_s;
      spike_r    <= spike_n_s;
      in_ready_r <= in_ready_n_s;
    end
  end

  assign nf.add_a    = vmem_r;
  assign nf.add_b    = add_b_r;
  assign nf.in_ready = in_ready_r;
  assign spike       = spike_r;
  assign vmem        = vmem_r;

endmodule

// File: tb/tb_neuron_accum_fire.sv
// Scoreboard bench: a saturating and a wrapping neuron share stimulus; accepts push predictions
// from an arithmetic reference model, a negedge monitor checks each in_ready-low window.
module tb_neuron_accum_fire;
  import neuron_pkg::*;

  localparam int S = 4;
  localparam int R = 3;

  typedef struct {
    int w;
    int vm;
    bit fire;
    int lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic [NW-1:0] in_weight = 10'd0;
  logic [NW-1:0] thresh = 10'd0;
  logic          spike0, spike1;
  logic [NW-1:0] vmem0, vmem1;

  neuron_accum_fire_if if0 ();
  neuron_accum_fire_if if1 ();

  always #5 clk = ~clk;

  assign if0.in_valid  = in_valid;
  assign if0.in_weight = in_weight;
  assign if1.in_valid  = in_valid;
  assign if1.in_weight = in_weight;
  assign {if0.add_cout, if0.add_sum} = {1'b0, if0.add_a} + {1'b0, if0.add_b};
  assign {if1.add_cout, if1.add_sum} = {1'b0, if1.add_a} + {1'b0, if1.add_b};

  neuron_accum_fire #(.SETTLE_CYC(S), .REFRAC_CYC(R), .VRESET(10'd0), .SAT(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .clear(clear), .nf(if0), .thresh(thresh),
    .spike(spike0), .vmem(vmem0)
  );

  neuron_accum_fire #(.SETTLE_CYC(S), .REFRAC_CYC(R), .VRESET(10'd0), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .clear(clear), .nf(if1), .thresh(thresh),
    .spike(spike1), .vmem(vmem1)
  );

  int   n_chk = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  bit   clr_armed = 1'b0;
  exp_t q0[$];
  exp_t q1[$];
  int   model_vm[2] = '{0, 0};
  int   acc_cnt[2] = '{0, 0};
  int   low_cnt[2], spk_cnt[2], spk_at[2];
  bit   prev_rdy[2] = '{1'b1, 1'b1};
  bit   cur_v[2] = '{1'b0, 1'b0};
  exp_t cur[2];

  task automatic chk(input string name, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the potential.
  function automatic exp_t predict(input int d, input int w);
    exp_t e;
    int s, nv;
    s = model_vm[d] + w;
    if (d == 0) nv = (s > 1023) ? 1023 : s;
    else        nv = s % 1024;
    e.w = w;
    if (clr_armed) begin
      e.fire = 1'b0; e.vm = 0; e.lat = S;
    end else begin
      e.fire = (nv >= int'(thresh));
      e.vm   = e.fire ? 0 : nv;
      e.lat  = e.fire ? (S + R + 1) : (S + 1);
    end
    return e;
  endfunction

  function automatic int next_vm(input int d, input int w);
    exp_t e;
    e = predict(d, w);
    return e.vm;
  endfunction

  // Accept observer: pushes one prediction per handshake.
  initial begin
    forever begin
      @(posedge clk);
      if (mon_en && rst_n) begin
        if (in_valid && if0.in_ready) begin
          q0.push_back(predict(0, int'(in_weight)));
          model_vm[0] = next_vm(0, int'(in_weight));
          acc_cnt[0]++;
        end
        if (in_valid && if1.in_ready) begin
          q1.push_back(predict(1, int'(in_weight)));
          model_vm[1] = next_vm(1, int'(in_weight));
          acc_cnt[1]++;
        end
        if (clear) begin
          model_vm[0] = 0;
          model_vm[1] = 0;
        end
      end
    end
  end

  task automatic mon_step(input int d);
    logic r, s;
    int v, a, b;
    r = (d == 0) ? if0.in_ready : if1.in_ready;
    s = (d == 0) ? spike0 : spike1;
    v = (d == 0) ? int'(vmem0) : int'(vmem1);
    a = (d == 0) ? int'(if0.add_a) : int'(if1.add_a);
    b = (d == 0) ? int'(if0.add_b) : int'(if1.add_b);
    if (!mon_en) begin
      cur_v[d] = 1'b0;
    end else if (!r) begin
      if (prev_rdy[d]) begin
        low_cnt[d] = 0; spk_cnt[d] = 0; spk_at[d] = -1;
        if (((d == 0) ? q0.size() : q1.size()) == 0) begin
          n_chk++; n_fail++; cur_v[d] = 1'b0;
          $display("FAIL dut%0d busy without accept: got in_ready 0 expected 1", d);
        end else begin
          if (d == 0) cur[d] = q0.pop_front(); else cur[d] = q1.pop_front();
          cur_v[d] = 1'b1;
        end
      end
      low_cnt[d]++;
      if (s) begin
        spk_cnt[d]++;
        if (spk_at[d] < 0) spk_at[d] = low_cnt[d];
      end
      if (cur_v[d]) chk($sformatf("dut%0d add_b", d), b, (low_cnt[d] <= S) ? cur[d].w : 0);
    end else if (!prev_rdy[d] && cur_v[d]) begin
      chk($sformatf("dut%0d busy_cycles", d), low_cnt[d], cur[d].lat);
      chk($sformatf("dut%0d vmem", d), v, cur[d].vm);
      chk($sformatf("dut%0d add_a", d), a, cur[d].vm);
      chk($sformatf("dut%0d spike_count", d), spk_cnt[d], cur[d].fire ? 1 : 0);
      if (cur[d].fire) chk($sformatf("dut%0d spike_at", d), spk_at[d], S + 1);
      cur_v[d] = 1'b0;
    end else if (s) begin
      chk($sformatf("dut%0d stray_spike", d), 1, 0);
    end
    prev_rdy[d] = r;
  endtask

  // Response monitor on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      mon_step(0);
      mon_step(1);
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!(if0.in_ready && if1.in_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_chk++; n_fail++;
      $display("FAIL wait_ready: got in_ready %b%b expected 11", if0.in_ready, if1.in_ready);
    end
  endtask

  task automatic send(input int w, input int th);
    @(negedge clk);
    wait_ready();
    thresh    = 10'(th);
    in_valid  = 1'b1;
    in_weight = 10'(w);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_weight = 10'($urandom_range(0, 1023));
  endtask

  task automatic burst(input int th, input int w0, input int w1, input int w2);
    int ws[3];
    int base;
    ws = '{w0, w1, w2};
    @(negedge clk);
    wait_ready();
    thresh   = 10'(th);
    base     = acc_cnt[0];
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      int n = 0;
      in_weight = 10'(ws[i]);
      while (acc_cnt[0] == base + i && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) begin
        n_chk++; n_fail++;
        $display("FAIL burst accept %0d: got none expected one within 50 cycles", i);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, " vmem0"}, int'(vmem0), 0);
    chk({tag, " add_a0"}, int'(if0.add_a), 0);
    chk({tag, " add_b0"}, int'(if0.add_b), 0);
    chk({tag, " spike0"}, int'(spike0), 0);
    chk({tag, " in_ready0"}, int'(if0.in_ready), 1);
    chk({tag, " vmem1"}, int'(vmem1), 0);
    chk({tag, " add_b1"}, int'(if1.add_b), 0);
    chk({tag, " spike1"}, int'(spike1), 0);
    chk({tag, " in_ready1"}, int'(if1.in_ready), 1);
  endtask

  initial begin
    #12;
    chk_idle_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // Asynchronous reset in the middle of SETTLE.
    @(negedge clk);
    in_valid = 1'b1; in_weight = 10'd77;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); @(posedge clk);
    #3;
    chk("pre_reset add_b0", int'(if0.add_b), 77);
    rst_n = 1'b0;
    #1;
    chk_idle_zero("mid_settle_reset");
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) mon_en = 1'b1;

    // Accumulate, fire, saturate versus wrap.
    send(100, 512);
    send(200, 512);
    send(300, 512);
    send(1000, 1023);
    send(100, 1023);

    // Resynchronise both potentials with an idle clear.
    @(negedge clk);
    wait_ready();
    clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    chk("idle_clear vmem0", int'(vmem0), 0);
    chk("idle_clear vmem1", int'(vmem1), 0);

    // in_valid held across busy windows.
    burst(1023, 10, 20, 30);
    burst(0, 5, 6, 7);

    for (int i = 0; i < 30; i++) begin
      send($urandom_range(0, 400), $urandom_range(0, 1023));
    end
    send(1023, 0);
    send(0, 1023);

    // Clear on the capture cycle of a transaction that would fire.
    @(negedge clk);
    wait_ready();
    thresh = 10'd0; clr_armed = 1'b1;
    in_valid = 1'b1; in_weight = 10'd50;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); @(posedge clk); @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0; clr_armed = 1'b0;
    chk_idle_zero("capture_clear");

    begin
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0 || cur_v[0] || cur_v[1]) && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) begin
        n_chk++; n_fail++;
        $display("FAIL drain: got %0d/%0d pending expected 0", q0.size(), q1.size());
      end
    end
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before 400000");
    $fatal(1);
  end

endmodule
